// File: rtl/bitonic_pkg.sv
// rtl/bitonic_pkg.sv - shared sizing and layer geometry for the bitonic sort pipeline
package bitonic_pkg;

    function automatic int log2_f(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int idx_width(input int k);
        int l;
        l = log2_f(k);
        return (l < 1) ? 1 : l;
    endfunction

    function automatic int num_stages(input int k);
        int l;
        l = log2_f(k);
        return (l * (l + 1)) / 2;
    endfunction

    // Layers are numbered phase by phase; phase p merges blocks of 2^(p+1) with distances 2^p .. 1.
    function automatic int layer_phase(input int t);
        int r;
        int c;
        r = 0;
        c = 0;
        for (int p = 0; p < 16; p++) begin
            for (int q = p; q >= 0; q--) begin
                if (c == t) r = p;
                c++;
            end
        end
        return r;
    endfunction

    function automatic int layer_sub(input int t);
        int r;
        int c;
        r = 0;
        c = 0;
        for (int p = 0; p < 16; p++) begin
            for (int q = p; q >= 0; q--) begin
                if (c == t) r = q;
                c++;
            end
        end
        return r;
    endfunction

    function automatic int layer_partner(input int i, input int q);
        return i ^ (1 << q);
    endfunction

    // Sub-sorts alternate by block parity; only the last phase follows the vector's own direction.
    function automatic logic cas_ascending(input int i, input int p, input int l, input logic dir);
        logic r;
        if (p == l - 1) r = dir;
        else            r = (((i >> (p + 1)) & 1) == 0);
        return r;
    endfunction

endpackage

// File: rtl/bitonic_cas_layer.sv
// rtl/bitonic_cas_layer.sv - one combinational layer of K/2 compare-swaps
module bitonic_cas_layer
    import bitonic_pkg::*;
#(
    parameter int W      = 64,
    parameter int K      = 16,
    parameter int SIGNED = 0,
    parameter int LAYER  = 0
) (
    input  logic                      dir_i,
    input  logic [K*W-1:0]            key_i,
    input  logic [K*idx_width(K)-1:0] idx_i,
    output logic [K*W-1:0]            key_o,
    output logic [K*idx_width(K)-1:0] idx_o
);
    localparam int L  = log2_f(K);
    localparam int IW = idx_width(K);
    localparam int P  = layer_phase(LAYER);
    localparam int Q  = layer_sub(LAYER);

    function automatic logic is_gt(input logic [W-1:0] a, input logic [W-1:0] b);
        logic r;
        if (SIGNED != 0) r = $signed(a) > $signed(b);
        else             r = a > b;
        return r;
    endfunction

    logic [W-1:0]  key_a;
    logic [W-1:0]  key_b;
    logic [IW-1:0] idx_a;
    logic [IW-1:0] idx_b;
    logic          swap;
    int            j;

    // Strict compare keeps equal keys in place.
    always_comb begin
        key_o = key_i;
        idx_o = idx_i;
        key_a = '0;
        key_b = '0;
        idx_a = '0;
        idx_b = '0;
        swap  = 1'b0;
        j     = 0;
        for (int i = 0; i < K; i++) begin
            if (((i >> Q) & 1) == 0) begin
                j     = layer_partner(i, Q);
                key_a = key_i[i*W +: W];
                key_b = key_i[j*W +: W];
                idx_a = idx_i[i*IW +: IW];
                idx_b = idx_i[j*IW +: IW];
                swap  = cas_ascending(i, P, L, dir_i) ? is_gt(key_a, key_b) : is_gt(key_b, key_a);
                if (swap) begin
                    key_o[i*W +: W]   = key_b;
                    key_o[j*W +: W]   = key_a;
                    idx_o[i*IW +: IW] = idx_b;
                    idx_o[j*IW +: IW] = idx_a;
                end
            end
        end
    end

endmodule

// File: rtl/bitonic_sort_pipe.sv
// rtl/bitonic_sort_pipe.sv - fully pipelined bitonic sorter with index tracking and global stall
module bitonic_sort_pipe
    import bitonic_pkg::*;
#(
    parameter int W      = 64,
    parameter int K      = 16,
    parameter int SIGNED = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [K*W-1:0]            in_array,
    input  logic                      in_dir,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [K*W-1:0]            out_array,
    output logic [K*idx_width(K)-1:0] out_idx,
    output logic                      out_valid,
    input  logic                      out_ready
);
    localparam int S  = num_stages(K);
    localparam int IW = idx_width(K);

    logic [K*W-1:0]  key_q     [S];
    logic [K*W-1:0]  key_d     [S];
    logic [K*W-1:0]  lay_key_i [S];
    logic [K*W-1:0]  lay_key_o [S];
    logic [K*IW-1:0] idx_q     [S];
    logic [K*IW-1:0] idx_d     [S];
    logic [K*IW-1:0] lay_idx_i [S];
    logic [K*IW-1:0] lay_idx_o [S];
    logic            dir_q     [S];
    logic            dir_d     [S];
    logic            lay_dir_i [S];
    logic            vld_q     [S];
    logic            vld_d     [S];
    logic            lay_vld_i [S];
    logic [K*IW-1:0] idx_init;
    logic            adv;

    // One stall signal for every rank keeps vectors in lockstep and in order.
    assign adv       = !vld_q[S-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[S-1];
    assign out_array = key_q[S-1];
    assign out_idx   = idx_q[S-1];

    always_comb begin
        idx_init = '0;
        for (int i = 0; i < K; i++) begin
            idx_init[i*IW +: IW] = IW'(i);
        end
    end

    always_comb begin
        lay_key_i[0] = in_array;
        lay_idx_i[0] = idx_init;
        lay_dir_i[0] = in_dir;
        lay_vld_i[0] = in_valid;
        for (int t = 1; t < S; t++) begin
            lay_key_i[t] = key_q[t-1];
            lay_idx_i[t] = idx_q[t-1];
            lay_dir_i[t] = dir_q[t-1];
            lay_vld_i[t] = vld_q[t-1];
        end
    end

    for (genvar t = 0; t < S; t++) begin : g_layer
        bitonic_cas_layer #(
            .W      (W),
            .K      (K),
            .SIGNED (SIGNED),
            .LAYER  (t)
        ) u_layer (
            .dir_i (lay_dir_i[t]),
            .key_i (lay_key_i[t]),
            .idx_i (lay_idx_i[t]),
            .key_o (lay_key_o[t]),
            .idx_o (lay_idx_o[t])
        );
    end

    always_comb begin
        for (int t = 0; t < S; t++) begin
            key_d[t] = key_q[t];
            idx_d[t] = idx_q[t];
            dir_d[t] = dir_q[t];
            vld_d[t] = vld_q[t];
            if (adv) begin
                key_d[t] = lay_key_o[t];
                idx_d[t] = lay_idx_o[t];
                dir_d[t] = lay_dir_i[t];
                vld_d[t] = lay_vld_i[t];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int t = 0; t < S; t++) begin
                key_q[t] <= '0;
                idx_q[t] <= '0;
                dir_q[t] <= 1'b0;
                vld_q[t] <= 1'b0;
            end
        end else begin
            for (int t = 0; t < S; t++) begin
                key_q[t] <= key_d[t];
                idx_q[t] <= idx_d[t];
                dir_q[t] <= dir_d[t];
                vld_q[t] <= vld_d[t];
            end
        end
    end

endmodule
